// File: rtl/handshake_pkg.sv
// Shared definitions for the valid/ready pipeline blocks.
// Holds the default beat width, the reset polarity and the occupancy width helper.
package handshake_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam logic RST_ACTIVE = 1'b1;

    // Bits needed to count 0..stages inclusive; never narrower than one bit.
    function automatic int cntWidth(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/valid_stage.sv
// One forward-registered pipeline stage: a valid flag and its data word.
// Reset beats clear, clear beats load; data is only rewritten when a valid beat arrives.
module valid_stage
    import handshake_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             valid_in,
    input  logic [0:width-1] data_in,
    output logic             valid_q,
    output logic [0:width-1] data_q
);

    logic             r_valid;
    logic [0:width-1] r_data;

    // Flush only drops the valid flag; a stale data word behind an empty flag is harmless.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_data <= data_in;
            end
        end
    end

    assign valid_q = r_valid;
    assign data_q  = r_data;

endmodule

// File: rtl/valid_flop_pipe.sv
// Forward-registered valid/ready pipeline with combinational ready, flush and occupancy count.
// Bubbles collapse: any empty stage accepts even while the consumer stalls.
module valid_flop_pipe
    import handshake_pkg::*;
#(
    parameter int width  = DEFAULT_WIDTH,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          valid_up,
    output logic                          ready_up,
    input  logic [0:width-1]              data_up,
    output logic                          valid_down,
    input  logic                          ready_down,
    output logic [0:width-1]              data_down,
    output logic [cntWidth(STAGES)-1:0]   occupancy
);

    localparam int CNT_W = cntWidth(STAGES);

    logic [STAGES-1:0] w_valid;
    logic [0:width-1]  w_data [STAGES];
    logic [STAGES:0]   w_rdy;
    logic              w_rstActive;
    logic              w_inHs;
    logic              w_outHs;
    logic [CNT_W-1:0]  r_occupancy;

    assign w_rstActive = (rst == RST_ACTIVE);

    // A stage may advance when it is empty or the stage after it advances too.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = ready_down;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_rdy[i] = ~w_valid[i] | w_rdy[i + 1];
        end
    end

    assign ready_up = w_rdy[0] & ~w_rstActive & ~flush;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             w_validIn;
        logic [0:width-1] w_dataIn;

        if (i == 0) begin : g_head
            assign w_validIn = valid_up;
            assign w_dataIn  = data_up;
        end else begin : g_body
            assign w_validIn = w_valid[i - 1];
            assign w_dataIn  = w_data[i - 1];
        end

        valid_stage #(
            .width(width)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clear    (flush),
            .load     (w_rdy[i]),
            .valid_in (w_validIn),
            .data_in  (w_dataIn),
            .valid_q  (w_valid[i]),
            .data_q   (w_data[i])
        );
    end

    assign valid_down = w_valid[STAGES - 1];
    assign data_down  = w_data[STAGES - 1];

    assign w_inHs  = valid_up & ready_up;
    assign w_outHs = valid_down & ready_down;

    // Occupancy tracks beats in minus beats out; a flush empties the pipe regardless of handshakes.
    always_ff @(posedge clk) begin
        if (w_rstActive) begin
            r_occupancy <= '0;
        end else if (flush) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= r_occupancy + CNT_W'(w_inHs) - CNT_W'(w_outHs);
        end
    end

    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_valid_flop_pipe.sv
// Directed and randomized checks of valid_flop_pipe at STAGES=2, with STAGES=1 and 3 scoreboarded.
module tb_valid_flop_pipe;

    logic       clk;
    logic       rst;

    logic       flush2, validUp2, readyUp2, validDown2, readyDown2;
    logic [0:3] dataUp2, dataDown2;
    logic [1:0] occ2;

    logic       flush1, validUp1, readyUp1, validDown1, readyDown1;
    logic [0:3] dataUp1, dataDown1;
    logic [0:0] occ1;

    logic       flush3, validUp3, readyUp3, validDown3, readyDown3;
    logic [0:3] dataUp3, dataDown3;
    logic [1:0] occ3;

    int checks;
    int failures;

    valid_flop_pipe #(.width(4), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .valid_up(validUp2), .ready_up(readyUp2),
        .data_up(dataUp2), .valid_down(validDown2), .ready_down(readyDown2),
        .data_down(dataDown2), .occupancy(occ2)
    );

    valid_flop_pipe #(.width(4), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .valid_up(validUp1), .ready_up(readyUp1),
        .data_up(dataUp1), .valid_down(validDown1), .ready_down(readyDown1),
        .data_down(dataDown1), .occupancy(occ1)
    );

    valid_flop_pipe #(.width(4), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3), .valid_up(validUp3), .ready_up(readyUp3),
        .data_up(dataUp3), .valid_down(validDown3), .ready_down(readyDown3),
        .data_down(dataDown3), .occupancy(occ3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkStream(input string name, input logic expValid, input logic [3:0] expData,
                               input int expOcc);
        checks++;
        if (validDown2 !== expValid || (expValid && dataDown2 !== expData) || int'(occ2) != expOcc) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%b data=%h occ=%0d, want valid=%b data=%h occ=%0d",
                     name, validDown2, dataDown2, occ2, expValid, expData, expOcc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        validUp2 = 1'b1;
        dataUp2 = 4'h5;
        readyDown2 = 1'b1;
        #1;
        checks++;
        if (readyUp2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_pre: got %b want 0", readyUp2);
        end
        tick();
        checks++;
        if (readyUp2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_hold: got %b want 0", readyUp2);
        end
        tick();
        checks++;
        if (validDown2 !== 1'b0 || dataDown2 !== 4'h0 || occ2 !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got valid=%b data=%h occ=%0d want 0/0/0",
                     validDown2, dataDown2, occ2);
        end
        checks++;
        if (occ1 !== 1'd0 || occ3 !== 2'd0 || validDown1 !== 1'b0 || validDown3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_others: got occ1=%0d occ3=%0d v1=%b v3=%b want 0",
                     occ1, occ3, validDown1, validDown3);
        end
        validUp2 = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_stream();
        readyDown2 = 1'b1;
        validUp2 = 1'b1;
        dataUp2 = 4'h1;
        #1;
        checks++;
        if (readyUp2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stream_ready: got %b want 1", readyUp2);
        end
        tick();
        checkStream("stream_e1", 1'b0, 4'h0, 1);
        dataUp2 = 4'h2;
        tick();
        checkStream("stream_e2", 1'b1, 4'h1, 2);
        dataUp2 = 4'h3;
        tick();
        checkStream("stream_e3", 1'b1, 4'h2, 2);
        validUp2 = 1'b0;
        tick();
        checkStream("stream_e4", 1'b1, 4'h3, 1);
        tick();
        checkStream("stream_e5", 1'b0, 4'h0, 0);
    endtask

    task automatic test_stall_fill();
        readyDown2 = 1'b0;
        validUp2 = 1'b1;
        dataUp2 = 4'hA;
        tick();
        checkStream("stall_a", 1'b0, 4'h0, 1);
        dataUp2 = 4'hB;
        #1;
        checks++;
        if (readyUp2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_ready_b: got %b want 1", readyUp2);
        end
        tick();
        checkStream("stall_full", 1'b1, 4'hA, 2);
        dataUp2 = 4'hC;
        #1;
        checks++;
        if (readyUp2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_ready_full: got %b want 0", readyUp2);
        end
        tick();
        checkStream("stall_hold", 1'b1, 4'hA, 2);
        readyDown2 = 1'b1;
        #1;
        checks++;
        if (readyUp2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_ready_release: got %b want 1", readyUp2);
        end
        tick();
        checkStream("drain_b", 1'b1, 4'hB, 2);
        validUp2 = 1'b0;
        tick();
        checkStream("drain_c", 1'b1, 4'hC, 1);
        tick();
        checkStream("drain_empty", 1'b0, 4'h0, 0);
    endtask

    task automatic test_bubble();
        readyDown2 = 1'b0;
        validUp2 = 1'b1;
        dataUp2 = 4'hD;
        tick();
        validUp2 = 1'b0;
        tick();
        checkStream("bubble_one", 1'b1, 4'hD, 1);
        validUp2 = 1'b1;
        dataUp2 = 4'hE;
        #1;
        checks++;
        if (readyUp2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bubble_ready: got %b want 1", readyUp2);
        end
        tick();
        checkStream("bubble_two", 1'b1, 4'hD, 2);
    endtask

    task automatic test_flush();
        dataUp2 = 4'hF;
        validUp2 = 1'b1;
        flush2 = 1'b1;
        #1;
        checks++;
        if (readyUp2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_ready: got %b want 0", readyUp2);
        end
        tick();
        flush2 = 1'b0;
        checkStream("flush_empty", 1'b0, 4'h0, 0);
        // The un-accepted beat is still offered and must arrive intact.
        readyDown2 = 1'b1;
        tick();
        validUp2 = 1'b0;
        tick();
        checkStream("flush_resend", 1'b1, 4'hF, 1);
        tick();
        checkStream("flush_drain", 1'b0, 4'h0, 0);
    endtask

    task automatic test_random(input int cycles);
        logic [3:0] q1[$];
        logic [3:0] q3[$];
        logic [3:0] expData;
        int model1, model3;
        model1 = 0;
        model3 = 0;
        for (int c = 0; c < cycles; c++) begin
            validUp1 = 1'($urandom_range(1));
            readyDown1 = 1'($urandom_range(1));
            dataUp1 = 4'($urandom_range(15));
            validUp3 = 1'($urandom_range(1));
            readyDown3 = 1'($urandom_range(3) != 0);
            dataUp3 = 4'($urandom_range(15));
            #1;
            if (validDown1 && readyDown1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand1_spurious: got data=%h with empty scoreboard", dataDown1);
                end else begin
                    expData = q1.pop_front();
                    if (dataDown1 !== expData) begin
                        failures++;
                        $display("[TB] FAIL rand1_data: got %h want %h", dataDown1, expData);
                    end
                end
                model1--;
            end
            if (validDown3 && readyDown3) begin
                checks++;
                if (q3.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand3_spurious: got data=%h with empty scoreboard", dataDown3);
                end else begin
                    expData = q3.pop_front();
                    if (dataDown3 !== expData) begin
                        failures++;
                        $display("[TB] FAIL rand3_data: got %h want %h", dataDown3, expData);
                    end
                end
                model3--;
            end
            if (validUp1 && readyUp1) begin
                q1.push_back(dataUp1);
                model1++;
            end
            if (validUp3 && readyUp3) begin
                q3.push_back(dataUp3);
                model3++;
            end
            tick();
            checks++;
            if (int'(occ1) != model1 || model1 > 1) begin
                failures++;
                $display("[TB] FAIL rand1_occ: got %0d want %0d", occ1, model1);
            end
            checks++;
            if (int'(occ3) != model3 || model3 > 3) begin
                failures++;
                $display("[TB] FAIL rand3_occ: got %0d want %0d", occ3, model3);
            end
        end
        validUp1 = 1'b0;
        validUp3 = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        flush2 = 1'b0; validUp2 = 1'b0; readyDown2 = 1'b0; dataUp2 = '0;
        flush1 = 1'b0; validUp1 = 1'b0; readyDown1 = 1'b0; dataUp1 = '0;
        flush3 = 1'b0; validUp3 = 1'b0; readyDown3 = 1'b0; dataUp3 = '0;
        test_reset();
        test_stream();
        test_stall_fill();
        test_bubble();
        test_flush();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
